// File: rtl/riscv_pipe_core.sv
// Five-stage in-order RV32I subset pipeline (IF, ID, EX, MEM, WB).
// Branches resolve in ID, EX has full forwarding, load-use and branch-source
// hazards stall ID by one bubble. ECALL drains the pipe and freezes the core.
module riscv_pipe_core #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned IMEM_AW  = 10,
  parameter int unsigned DMEM_AW  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clock,
  input  logic               resetn,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               dmem_we,
  input  logic [31:0]        dmem_rdata,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_count
);

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  localparam logic [31:0] EcallInstr = 32'h0000_0073;

  // Fetch / IF-ID state
  logic [31:0] r_pc;
  logic        r_fetch_stop;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;

  // ID-EX state
  logic        r_idex_valid;
  logic [4:0]  r_idex_rd;
  logic [4:0]  r_idex_rs1;
  logic [4:0]  r_idex_rs2;
  logic [31:0] r_idex_rs1_val;
  logic [31:0] r_idex_rs2_val;
  logic [31:0] r_idex_imm;
  alu_op_e     r_idex_alu_op;
  logic        r_idex_use_imm;
  logic        r_idex_wen;
  logic        r_idex_is_lw;
  logic        r_idex_is_sw;
  logic        r_idex_is_ecall;

  // EX-MEM state
  logic        r_exmem_valid;
  logic [31:0] r_exmem_alu;
  logic [31:0] r_exmem_sdata;
  logic [4:0]  r_exmem_rd;
  logic        r_exmem_wen;
  logic        r_exmem_is_lw;
  logic        r_exmem_is_sw;
  logic        r_exmem_is_ecall;

  // MEM-WB state
  logic        r_memwb_valid;
  logic [31:0] r_memwb_val;
  logic [4:0]  r_memwb_rd;
  logic        r_memwb_wen;
  logic        r_memwb_is_ecall;

  logic [31:0]      r_rf [32];
  logic             r_halted;
  logic [CNT_W-1:0] r_retire;

  // ID decode
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_i_imm;
  logic [31:0] w_s_imm;
  logic [31:0] w_b_imm;
  logic        w_dec_wen;
  logic        w_dec_lw;
  logic        w_dec_sw;
  logic        w_dec_beq;
  logic        w_dec_bne;
  logic        w_dec_ecall;
  logic        w_dec_use_imm;
  logic        w_dec_use_rs1;
  logic        w_dec_use_rs2;
  logic [31:0] w_dec_imm;
  alu_op_e     w_dec_alu_op;

  // Hazards, register read and branch resolution
  logic        w_wb_we;
  logic [31:0] w_rs1_rf;
  logic [31:0] w_rs2_rf;
  logic [31:0] w_br_a;
  logic [31:0] w_br_b;
  logic        w_load_use;
  logic        w_br_hazard;
  logic        w_stall;
  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_id_ecall;

  // EX datapath
  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_res;
  logic [31:0] w_mem_val;

  assign w_opcode = r_ifid_instr[6:0];
  assign w_f3     = r_ifid_instr[14:12];
  assign w_f7     = r_ifid_instr[31:25];
  assign w_rd     = r_ifid_instr[11:7];
  assign w_rs1    = r_ifid_instr[19:15];
  assign w_rs2    = r_ifid_instr[24:20];
  assign w_i_imm  = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
  assign w_s_imm  = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
  assign w_b_imm  = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                     r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};

  // Instruction decode; unrecognised encodings fall through as side-effect-free no-ops
  always_comb begin
    w_dec_wen     = 1'b0;
    w_dec_lw      = 1'b0;
    w_dec_sw      = 1'b0;
    w_dec_beq     = 1'b0;
    w_dec_bne     = 1'b0;
    w_dec_ecall   = 1'b0;
    w_dec_use_imm = 1'b0;
    w_dec_use_rs1 = 1'b0;
    w_dec_use_rs2 = 1'b0;
    w_dec_imm     = w_i_imm;
    w_dec_alu_op  = AluAdd;
    if (r_ifid_instr == EcallInstr) begin
      w_dec_ecall = 1'b1;
    end else begin
      case (w_opcode)
        7'b0000011: begin
          if (w_f3 == 3'b010) begin
            w_dec_lw      = 1'b1;
            w_dec_wen     = 1'b1;
            w_dec_use_imm = 1'b1;
            w_dec_use_rs1 = 1'b1;
          end
        end
        7'b0100011: begin
          if (w_f3 == 3'b010) begin
            w_dec_sw      = 1'b1;
            w_dec_use_imm = 1'b1;
            w_dec_imm     = w_s_imm;
            w_dec_use_rs1 = 1'b1;
            w_dec_use_rs2 = 1'b1;
          end
        end
        7'b1100011: begin
          if (w_f3 == 3'b000 || w_f3 == 3'b001) begin
            w_dec_beq     = (w_f3 == 3'b000);
            w_dec_bne     = (w_f3 == 3'b001);
            w_dec_use_rs1 = 1'b1;
            w_dec_use_rs2 = 1'b1;
          end
        end
        7'b0110011: begin
          if (w_f7 == 7'b0000000) begin
            case (w_f3)
              3'b000:  begin w_dec_wen = 1'b1; w_dec_alu_op = AluAdd; end
              3'b111:  begin w_dec_wen = 1'b1; w_dec_alu_op = AluAnd; end
              3'b110:  begin w_dec_wen = 1'b1; w_dec_alu_op = AluOr;  end
              3'b010:  begin w_dec_wen = 1'b1; w_dec_alu_op = AluSlt; end
              default: ;
            endcase
          end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
            w_dec_wen    = 1'b1;
            w_dec_alu_op = AluSub;
          end
          w_dec_use_rs1 = w_dec_wen;
          w_dec_use_rs2 = w_dec_wen;
        end
        7'b0010011: begin
          case (w_f3)
            3'b000:  begin w_dec_wen = 1'b1; w_dec_alu_op = AluAdd; end
            3'b010:  begin w_dec_wen = 1'b1; w_dec_alu_op = AluSlt; end
            3'b111:  begin w_dec_wen = 1'b1; w_dec_alu_op = AluAnd; end
            3'b110:  begin w_dec_wen = 1'b1; w_dec_alu_op = AluOr;  end
            default: ;
          endcase
          w_dec_use_imm = w_dec_wen;
          w_dec_use_rs1 = w_dec_wen;
        end
        default: ;
      endcase
    end
  end

  // Register read with write-through from the WB stage; x0 always reads zero
  always_comb begin
    w_wb_we = r_memwb_valid && r_memwb_wen && (r_memwb_rd != 5'd0);
    if (w_rs1 == 5'd0)                       w_rs1_rf = 32'h0;
    else if (w_wb_we && r_memwb_rd == w_rs1) w_rs1_rf = r_memwb_val;
    else                                     w_rs1_rf = r_rf[w_rs1];
    if (w_rs2 == 5'd0)                       w_rs2_rf = 32'h0;
    else if (w_wb_we && r_memwb_rd == w_rs2) w_rs2_rf = r_memwb_val;
    else                                     w_rs2_rf = r_rf[w_rs2];
  end

  // Branch operands: an ALU result sitting in MEM is forwarded back into ID
  always_comb begin
    w_br_a = w_rs1_rf;
    w_br_b = w_rs2_rf;
    if (r_exmem_valid && r_exmem_wen && !r_exmem_is_lw && r_exmem_rd != 5'd0) begin
      if (r_exmem_rd == w_rs1) w_br_a = r_exmem_alu;
      if (r_exmem_rd == w_rs2) w_br_b = r_exmem_alu;
    end
  end

  // Hazard detection and branch decision; a stall always overrides the branch
  always_comb begin
    w_load_use  = r_ifid_valid && r_idex_valid && r_idex_is_lw && (r_idex_rd != 5'd0) &&
                  ((w_dec_use_rs1 && r_idex_rd == w_rs1) ||
                   (w_dec_use_rs2 && r_idex_rd == w_rs2));
    w_br_hazard = r_ifid_valid && (w_dec_beq || w_dec_bne) &&
                  ((r_idex_valid && r_idex_wen && (r_idex_rd != 5'd0) &&
                    (r_idex_rd == w_rs1 || r_idex_rd == w_rs2)) ||
                   (r_exmem_valid && r_exmem_is_lw && (r_exmem_rd != 5'd0) &&
                    (r_exmem_rd == w_rs1 || r_exmem_rd == w_rs2)));
    w_stall     = w_load_use || w_br_hazard;
    w_br_taken  = r_ifid_valid && !w_stall &&
                  ((w_dec_beq && (w_br_a == w_br_b)) || (w_dec_bne && (w_br_a != w_br_b)));
    w_br_target = r_ifid_pc + w_b_imm;
    w_id_ecall  = r_ifid_valid && w_dec_ecall;
  end

  // EX operand forwarding: EX/MEM ALU result first, then MEM/WB value, then ID/EX copy
  always_comb begin
    w_fwd_a = r_idex_rs1_val;
    w_fwd_b = r_idex_rs2_val;
    if (r_exmem_valid && r_exmem_wen && !r_exmem_is_lw && r_exmem_rd != 5'd0 &&
        r_exmem_rd == r_idex_rs1) begin
      w_fwd_a = r_exmem_alu;
    end else if (r_memwb_valid && r_memwb_wen && r_memwb_rd != 5'd0 &&
                 r_memwb_rd == r_idex_rs1) begin
      w_fwd_a = r_memwb_val;
    end
    if (r_exmem_valid && r_exmem_wen && !r_exmem_is_lw && r_exmem_rd != 5'd0 &&
        r_exmem_rd == r_idex_rs2) begin
      w_fwd_b = r_exmem_alu;
    end else if (r_memwb_valid && r_memwb_wen && r_memwb_rd != 5'd0 &&
                 r_memwb_rd == r_idex_rs2) begin
      w_fwd_b = r_memwb_val;
    end
    w_alu_b = r_idex_use_imm ? r_idex_imm : w_fwd_b;
  end

  // ALU
  always_comb begin
    w_alu_res = 32'h0;
    unique case (r_idex_alu_op)
      AluAdd:  w_alu_res = w_fwd_a + w_alu_b;
      AluSub:  w_alu_res = w_fwd_a - w_alu_b;
      AluAnd:  w_alu_res = w_fwd_a & w_alu_b;
      AluOr:   w_alu_res = w_fwd_a | w_alu_b;
      AluSlt:  w_alu_res = {31'h0, $signed(w_fwd_a) < $signed(w_alu_b)};
      default: w_alu_res = 32'h0;
    endcase
  end

  assign w_mem_val = r_exmem_is_lw ? dmem_rdata : r_exmem_alu;

  // PC and IF/ID: stall holds, taken branch squashes, ECALL stops fetch for good
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_pc         <= RESET_PC;
      r_fetch_stop <= 1'b0;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 32'h0;
      r_ifid_instr <= 32'h0;
    end else if (!r_halted && !w_stall) begin
      if (w_br_taken) begin
        r_pc         <= w_br_target;
        r_ifid_valid <= 1'b0;
      end else if (r_fetch_stop || w_id_ecall) begin
        r_fetch_stop <= 1'b1;
        r_ifid_valid <= 1'b0;
      end else begin
        r_pc         <= r_pc + 32'd4;
        r_ifid_valid <= 1'b1;
        r_ifid_pc    <= r_pc;
        r_ifid_instr <= imem_rdata;
      end
    end
  end

  // ID/EX register; a stall injects a bubble
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_idex_valid    <= 1'b0;
      r_idex_rd       <= 5'd0;
      r_idex_rs1      <= 5'd0;
      r_idex_rs2      <= 5'd0;
      r_idex_rs1_val  <= 32'h0;
      r_idex_rs2_val  <= 32'h0;
      r_idex_imm      <= 32'h0;
      r_idex_alu_op   <= AluAdd;
      r_idex_use_imm  <= 1'b0;
      r_idex_wen      <= 1'b0;
      r_idex_is_lw    <= 1'b0;
      r_idex_is_sw    <= 1'b0;
      r_idex_is_ecall <= 1'b0;
    end else if (!r_halted) begin
      r_idex_valid    <= r_ifid_valid && !w_stall;
      r_idex_rd       <= w_rd;
      r_idex_rs1      <= w_dec_use_rs1 ? w_rs1 : 5'd0;
      r_idex_rs2      <= w_dec_use_rs2 ? w_rs2 : 5'd0;
      r_idex_rs1_val  <= w_rs1_rf;
      r_idex_rs2_val  <= w_rs2_rf;
      r_idex_imm      <= w_dec_imm;
      r_idex_alu_op   <= w_dec_alu_op;
      r_idex_use_imm  <= w_dec_use_imm;
      r_idex_wen      <= w_dec_wen;
      r_idex_is_lw    <= w_dec_lw;
      r_idex_is_sw    <= w_dec_sw;
      r_idex_is_ecall <= w_dec_ecall;
    end
  end

  // EX/MEM and MEM/WB registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_exmem_valid    <= 1'b0;
      r_exmem_alu      <= 32'h0;
      r_exmem_sdata    <= 32'h0;
      r_exmem_rd       <= 5'd0;
      r_exmem_wen      <= 1'b0;
      r_exmem_is_lw    <= 1'b0;
      r_exmem_is_sw    <= 1'b0;
      r_exmem_is_ecall <= 1'b0;
      r_memwb_valid    <= 1'b0;
      r_memwb_val      <= 32'h0;
      r_memwb_rd       <= 5'd0;
      r_memwb_wen      <= 1'b0;
      r_memwb_is_ecall <= 1'b0;
    end else if (!r_halted) begin
      r_exmem_valid    <= r_idex_valid;
      r_exmem_alu      <= w_alu_res;
      r_exmem_sdata    <= w_fwd_b;
      r_exmem_rd       <= r_idex_rd;
      r_exmem_wen      <= r_idex_wen;
      r_exmem_is_lw    <= r_idex_is_lw;
      r_exmem_is_sw    <= r_idex_is_sw;
      r_exmem_is_ecall <= r_idex_is_ecall;
      r_memwb_valid    <= r_exmem_valid;
      r_memwb_val      <= w_mem_val;
      r_memwb_rd       <= r_exmem_rd;
      r_memwb_wen      <= r_exmem_wen;
      r_memwb_is_ecall <= r_exmem_is_ecall;
    end
  end

  // Register file write in WB; x0 is never written
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
    end else if (!r_halted && w_wb_we) begin
      r_rf[r_memwb_rd] <= r_memwb_val;
    end
  end

  // Retire counter (saturating) and halt flag set as ECALL leaves WB
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_retire <= '0;
      r_halted <= 1'b0;
    end else if (!r_halted && r_memwb_valid) begin
      if (r_retire != {CNT_W{1'b1}}) r_retire <= r_retire + CNT_W'(1);
      if (r_memwb_is_ecall) r_halted <= 1'b1;
    end
  end

  assign imem_addr    = r_pc[IMEM_AW+1:2];
  assign dmem_addr    = r_exmem_alu[DMEM_AW+1:2];
  assign dmem_wdata   = r_exmem_sdata;
  assign dmem_we      = r_exmem_valid && r_exmem_is_sw && resetn && !r_halted;
  assign halted       = r_halted;
  assign retire_count = r_retire;

endmodule

// File: tb/tb_riscv_pipe_core.sv
// Directed bench for riscv_pipe_core: stores are checked by a scoreboard monitor,
// halt timing, retire counts and reset behaviour by direct checks.
module tb_riscv_pipe_core;
  localparam int unsigned IMEM_AW = 10;
  localparam int unsigned DMEM_AW = 10;
  localparam int unsigned CNT_W   = 32;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic               dmem_we;
  logic [31:0]        dmem_rdata;
  logic               halted;
  logic [CNT_W-1:0]   retire_count;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_e;

  riscv_pipe_core #(
    .RESET_PC (32'h0),
    .IMEM_AW  (IMEM_AW),
    .DMEM_AW  (DMEM_AW),
    .CNT_W    (CNT_W)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_we      (dmem_we),
    .dmem_rdata   (dmem_rdata),
    .halted       (halted),
    .retire_count (retire_count)
  );

  always #5 clock = ~clock;

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clock) begin
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  // Store monitor: every dmem_we pulse must match the head of the expected queue
  always @(negedge clock) begin
    if (dmem_we) begin
      n_vec++;
      if (!resetn) begin
        n_err++;
        $display("FAIL store_in_reset: got we=1 addr=%0d, required we=0", dmem_addr);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_store: got addr=%0d data=%h, required no store",
                 dmem_addr, dmem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (32'(dmem_addr) !== mon_e[63:32] || dmem_wdata !== mon_e[31:0]) begin
          n_err++;
          $display("FAIL store: got addr=%0d data=%h, required addr=%0d data=%h",
                   dmem_addr, dmem_wdata, mon_e[63:32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_store(input int addr, input logic [31:0] data);
    exp_q.push_back({32'(addr), data});
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] slti(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 2, rd, 7'h13);
  endfunction
  function automatic logic [31:0] andi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 7, rd, 7'h13);
  endfunction
  function automatic logic [31:0] ori(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 6, rd, 7'h13);
  endfunction
  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 2, rd, 7'h03);
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] rtype(input int f7, input int f3, input int rd,
                                        input int rs1, input int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int off);
    return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
  endfunction

  localparam logic [31:0] Ecall = 32'h0000_0073;

  // Hold reset for two edges and wipe both memories; returns #1 after a rising edge
  task automatic reset_and_clear();
    resetn = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Release reset and count edges until halted rises
  task automatic run_to_halt(input string name, input int req_cycles, input int req_retire);
    int n;
    n = 0;
    resetn = 1'b1;
    while (!halted && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_halt_cycles"}, 32'(n), 32'(req_cycles));
    check({name, "_halted"}, 32'(halted), 32'd1);
    check({name, "_retire"}, retire_count, 32'(req_retire));
    check({name, "_stores_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_queue_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Forwarding chain, no stalls, halt timing
    reset_and_clear();
    imem[0] = addi(1, 0, 5);
    imem[1] = addi(2, 1, 3);
    imem[2] = rtype(0, 0, 3, 1, 2);
    imem[3] = Ecall;
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retire", retire_count, 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    run_to_halt("chain", 8, 4);

    // ALU mix, SW/LW, load-use stall, untaken BNE, x0 discard, unknown op
    reset_and_clear();
    imem[0]  = addi(1, 0, 5);
    imem[1]  = addi(2, 1, 3);
    imem[2]  = rtype(0, 0, 3, 1, 2);         // x3 = 13
    imem[3]  = sw(3, 0, 0);
    imem[4]  = lw(4, 0, 0);
    imem[5]  = rtype(0, 0, 5, 4, 4);         // x5 = 26 after one stall
    imem[6]  = sw(5, 0, 4);
    imem[7]  = br(1, 0, 0, 16);              // BNE x0,x0: never taken
    imem[8]  = rtype(32, 0, 6, 1, 2);        // SUB x6 = -3
    imem[9]  = sw(6, 0, 8);
    imem[10] = rtype(0, 2, 7, 6, 1);         // SLT -3 < 5
    imem[11] = slti(8, 1, -1);               // 5 < -1 false
    imem[12] = andi(9, 6, 12'h0f0);
    imem[13] = ori(10, 8, -16);
    imem[14] = rtype(0, 7, 11, 9, 10);       // AND
    imem[15] = rtype(0, 6, 12, 7, 11);       // OR
    imem[16] = sw(7, 0, 12);
    imem[17] = sw(8, 0, 16);
    imem[18] = sw(10, 0, 20);
    imem[19] = sw(12, 0, 24);
    imem[20] = addi(0, 0, 7);
    imem[21] = sw(0, 0, 28);
    imem[22] = 32'hffff_ffff;
    imem[23] = Ecall;
    expect_store(0, 32'd13);
    expect_store(1, 32'd26);
    expect_store(2, 32'hffff_fffd);
    expect_store(3, 32'd1);
    expect_store(4, 32'd0);
    expect_store(5, 32'hffff_fff0);
    expect_store(6, 32'h0000_00f1);
    expect_store(7, 32'd0);
    run_to_halt("mix", 29, 24);

    // Taken BEQ behind a dependent ADDI: one stall, one squash; then frozen hold
    reset_and_clear();
    imem[0] = addi(1, 0, 1);
    imem[1] = br(0, 1, 1, 8);
    imem[2] = addi(6, 0, 9);                 // squashed
    imem[3] = sw(6, 0, 0);
    imem[4] = sw(1, 0, 4);
    imem[5] = Ecall;
    expect_store(0, 32'd0);
    expect_store(1, 32'd1);
    run_to_halt("branch", 11, 5);
    check("branch_halt_imem_addr", 32'(imem_addr), 32'd6);
    repeat (20) @(posedge clock);
    #1;
    check("hold_imem_addr", 32'(imem_addr), 32'd6);
    check("hold_retire", retire_count, 32'd5);
    check("hold_halted", 32'(halted), 32'd1);

    // Reset pulse while a loop's SW sits in MEM
    reset_and_clear();
    imem[0] = addi(1, 1, 1);
    imem[1] = sw(1, 0, 0);
    imem[2] = br(0, 0, 0, -8);
    expect_store(0, 32'd1);
    expect_store(0, 32'd2);
    expect_store(0, 32'd3);
    resetn = 1'b1;
    wait_queue_empty("loop_first");
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_imem_addr", 32'(imem_addr), 32'd0);
    check("midrst_retire", retire_count, 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    check("midrst_dmem_we", 32'(dmem_we), 32'd0);
    check("midrst_mem_word", dmem[0], 32'd3);
    expect_store(0, 32'd1);
    expect_store(0, 32'd2);
    resetn = 1'b1;
    wait_queue_empty("loop_restart");
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
